joy_db15_tx: RTL and testbench
==============================

Name: joy_db15_tx

Overview:
- Adapter-side emulation of the DB15 serial joystick interface: the responder for the host-side DB15 reader, which drives JOY_CLK and JOY_LOAD and samples JOY_DATA.
- Models a parallel-in/serial-out register chain (74HC165 style) holding two 16-bit player words.
- Used for loopback verification of the UserIO joystick path and as a bridge when a core must present local controls on a DB15 host port.
- Runs on the joystick clock domain (40-50 MHz); host-side pins are asynchronous and are synchronised internally.

Parameters:
- FRAME_BITS, 32: bits per frame; must equal 2 x WORD_BITS.
- WORD_BITS, 16: bits per player word.
- SYNC_STAGES, 2: synchroniser flops on JOY_CLK and JOY_LOAD; minimum 2.
- TIMEOUT, 24'd5_000_000: clk cycles with no load before host_active drops (100 ms at 50 MHz).

Ports:
- clk, in, 1: joystick clock, 40-50 MHz.
- reset, in, 1: synchronous, active-high.
- joystick1, in, WORD_BITS: player 1 controls, active-high (1 = pressed).
- joystick2, in, WORD_BITS: player 2 controls, active-high.
- JOY_CLK, in, 1: host shift clock, asynchronous. Shifts on its rising edge.
- JOY_LOAD, in, 1: host load, asynchronous, active-low.
- JOY_DATA, out, 1: serial data to host, active-low (0 = pressed).
- frame_done, out, 1: one-cycle pulse when the last frame bit has been shifted.
- bit_cnt, out, 6: bits shifted since the last load, saturating at FRAME_BITS.
- overrun, out, 1: sticky flag; set when the host clocks past the end of the frame.
- host_active, out, 1: a load was seen within the last TIMEOUT cycles.

Behaviour:
- Reset values:
  - shift register all ones, so JOY_DATA = 1.
  - bit_cnt = 0, frame_done = 0, overrun = 0, host_active = 0.
  - watchdog counter = 0.
  - synchroniser chains preset to 1 (idle high).
- Synchronisation: JOY_CLK and JOY_LOAD each pass through SYNC_STAGES flops. Edge detection compares the last sync stage with one extra delay flop.
- Load (synced JOY_LOAD = 0), level-sensitive and transparent:
  - each cycle, sr <= ~{joystick2, joystick1}, so sr[0] = ~joystick1[0].
  - bit_cnt <= 0.
  - Any JOY_CLK edge during load is ignored.
- Load falling edge (synced):
  - overrun <= 0.
  - watchdog <= 0.
  - host_active <= 1.
- Shift (synced JOY_CLK rising edge while synced JOY_LOAD = 1):
  - sr <= {1'b1, sr[FRAME_BITS-1:1]}; the serial input is tied high.
  - If bit_cnt < FRAME_BITS: bit_cnt++.
  - If bit_cnt becomes FRAME_BITS on this edge: frame_done = 1 on the next cycle only.
  - If bit_cnt was already FRAME_BITS: overrun <= 1, bit_cnt holds, JOY_DATA stays 1.
- Bit order after load:
  - edges 0..15 present ~joystick1[0..15].
  - edges 16..31 present ~joystick2[0..15].
  - JOY_DATA always equals sr[0] (registered, glitch-free).
- Latency:
  - JOY_DATA reflects a JOY_CLK pin edge SYNC_STAGES+2 clk cycles later.
  - During load, JOY_DATA tracks joystick1[0] with 1 cycle of latency.
  - The host must hold each JOY_CLK/JOY_LOAD phase for at least SYNC_STAGES+2 clk cycles. Shorter pulses may be lost; this is not detected.
- Watchdog:
  - increments each cycle while host_active = 1, saturating.
  - reaching TIMEOUT clears host_active and stops the counter.
  - the next load falling edge restarts it.
- Simultaneous events:
  - load low plus a JOY_CLK edge in the same cycle: the load wins.
  - a load falling edge in the same cycle as an overrun edge: the clear wins.
- Joystick inputs changing during a shift: the frame already latched is unaffected; new values are taken only by the next load.
- Reset mid-frame: all state returns to reset values in the next cycle. The host simply reads 1s until it issues a new load.

Test Plan:
- Basic frame: joystick1=16'h0001, joystick2=16'h8000, load pulse, then 32 clocks. Required: JOY_DATA reads 0 at bit 0 and bit 31, 1 elsewhere. frame_done pulses once after edge 32; bit_cnt=32; overrun=0.
- Overrun: after a full frame, send 3 extra clocks. Required: JOY_DATA=1 on all three, overrun=1, bit_cnt stays 32. The next load clears overrun; bit_cnt=0.
- Load priority: hold JOY_LOAD low while toggling JOY_CLK 5 times. Required: bit_cnt stays 0 and JOY_DATA tracks ~joystick1[0] as joystick1 is changed.
- Mid-frame input change: load with joystick1=16'hFFFF, shift 4 bits, change joystick1 to 0. Required: the remaining bits 4-15 still read 0 (pressed) until the next load.
- Watchdog (TIMEOUT overridden to 100): one load, then idle. Required: host_active=1 for 100 cycles, then 0. A second load sets it back to 1.
- Reset mid-frame: assert reset after 10 shifts. Required: next cycle JOY_DATA=1, bit_cnt=0, host_active=0. A fresh load and 32 clocks deliver the correct frame.

Source files
------------

// File: rtl/joy_db15_tx.sv
// joy_db15_tx: DB15 joystick responder. Emulates a 74HC165-style PISO chain
// holding two player words, clocked and loaded by an asynchronous host.
module joy_db15_tx #(
  parameter int          FRAME_BITS  = 32,
  parameter int          WORD_BITS   = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [23:0] TIMEOUT     = 24'd5_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] joystick1,
  input  logic [WORD_BITS-1:0] joystick2,
  input  logic                 JOY_CLK,
  input  logic                 JOY_LOAD,
  output logic                 JOY_DATA,
  output logic                 frame_done,
  output logic [5:0]           bit_cnt,
  output logic                 overrun,
  output logic                 host_active
);

  localparam logic [5:0] FULL = 6'(FRAME_BITS);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
  logic                   clk_dly_q, clk_dly_d;
  logic                   load_dly_q, load_dly_d;
  logic [FRAME_BITS-1:0]  sr_q, sr_d;
  logic [5:0]             cnt_q, cnt_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overrun_q, overrun_d;
  logic                   active_q, active_d;
  logic [23:0]            wd_q, wd_d;

  logic clk_s, load_s, clk_rise, load_fall, shift;

  // Load is level-sensitive and overrides shifting; the load falling edge
  // clears overrun and restarts the watchdog regardless of shift activity.
  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], JOY_CLK};
    load_sync_d  = {load_sync_q[SYNC_STAGES-2:0], JOY_LOAD};
    clk_s        = clk_sync_q[SYNC_STAGES-1];
    load_s       = load_sync_q[SYNC_STAGES-1];
    clk_dly_d    = clk_s;
    load_dly_d   = load_s;
    clk_rise     = clk_s & ~clk_dly_q;
    load_fall    = ~load_s & load_dly_q;
    shift        = clk_rise & load_s;

    sr_d         = sr_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    active_d     = active_q;
    wd_d         = wd_q;

    if (!load_s) begin
      sr_d  = ~{joystick2, joystick1};
      cnt_d = '0;
    end else if (shift) begin
      sr_d = {1'b1, sr_q[FRAME_BITS-1:1]};
      if (cnt_q < FULL) begin
        cnt_d        = cnt_q + 6'd1;
        frame_done_d = (cnt_q == FULL - 6'd1);
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (load_fall) begin
      overrun_d = 1'b0;
      wd_d      = '0;
      active_d  = 1'b1;
    end else if (active_q) begin
      wd_d = wd_q + 24'd1;
      if (wd_d == TIMEOUT) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q   <= '1;
      load_sync_q  <= '1;
      clk_dly_q    <= 1'b1;
      load_dly_q   <= 1'b1;
      sr_q         <= '1;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      active_q     <= 1'b0;
      wd_q         <= '0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      load_sync_q  <= load_sync_d;
      clk_dly_q    <= clk_dly_d;
      load_dly_q   <= load_dly_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      active_q     <= active_d;
      wd_q         <= wd_d;
    end
  end

  assign JOY_DATA    = sr_q[0];
  assign frame_done  = frame_done_q;
  assign bit_cnt     = cnt_q;
  assign overrun     = overrun_q;
  assign host_active = active_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: table-driven frames with a scoreboard queue of
// expected serial bits, plus overrun, load-priority, reset and watchdog cases.
module tb_joy_db15_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] joystick1 = '0;
  logic [15:0] joystick2 = '0;
  logic        JOY_CLK = 1'b0;
  logic        JOY_LOAD = 1'b1;
  logic        JOY_DATA;
  logic        frame_done;
  logic [5:0]  bit_cnt;
  logic        overrun;
  logic        host_active;

  int tests = 0;
  int fails = 0;
  int fd_total = 0;

  logic exp_q[$];

  typedef struct {
    logic [15:0] j1;
    logic [15:0] j2;
    logic [15:0] j1_mid;
    int          chg_at;
    logic [31:0] exp_bits;
  } frame_t;

  typedef struct {
    logic [15:0] j1;
    logic        exp_data;
  } prio_t;

  frame_t frames[3];
  prio_t  prio[5];

  joy_db15_tx #(
    .FRAME_BITS (32),
    .WORD_BITS  (16),
    .SYNC_STAGES(2),
    .TIMEOUT    (24'd100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .JOY_CLK    (JOY_CLK),
    .JOY_LOAD   (JOY_LOAD),
    .JOY_DATA   (JOY_DATA),
    .frame_done (frame_done),
    .bit_cnt    (bit_cnt),
    .overrun    (overrun),
    .host_active(host_active)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_total++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load();
    JOY_LOAD = 1'b0;
    hold(8);
    JOY_LOAD = 1'b1;
    hold(8);
  endtask

  task automatic pulse_clk();
    JOY_CLK = 1'b1;
    hold(8);
    JOY_CLK = 1'b0;
    hold(8);
  endtask

  task automatic read_bits(input int from, input int to, input string name);
    logic e;
    for (int k = from; k <= to; k++) begin
      if (exp_q.size() == 0) begin
        check({name, " queue empty"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s bit%0d", name, k), {31'd0, JOY_DATA}, {31'd0, e});
      end
      pulse_clk();
    end
  endtask

  task automatic run_frame(input frame_t f, input string name);
    int fd0;
    logic [31:0] eb;
    eb = f.exp_bits;
    joystick1 = f.j1;
    joystick2 = f.j2;
    for (int k = 0; k < 32; k++) exp_q.push_back(eb[k]);
    do_load();
    check({name, " bit_cnt after load"}, {26'd0, bit_cnt}, 32'd0);
    fd0 = fd_total;
    if (f.chg_at < 32) begin
      read_bits(0, f.chg_at - 1, name);
      joystick1 = f.j1_mid;
      read_bits(f.chg_at, 31, name);
    end else begin
      read_bits(0, 31, name);
    end
    check({name, " bit_cnt"}, {26'd0, bit_cnt}, 32'd32);
    check({name, " frame_done count"}, fd_total - fd0, 32'd1);
    check({name, " overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    int act_cnt;

    frames[0] = '{j1: 16'h0001, j2: 16'h8000, j1_mid: 16'h0000, chg_at: 32, exp_bits: 32'h7FFF_FFFE};
    frames[1] = '{j1: 16'hFFFF, j2: 16'h0000, j1_mid: 16'h0000, chg_at: 4,  exp_bits: 32'hFFFF_0000};
    frames[2] = '{j1: 16'hA5C3, j2: 16'h0F0F, j1_mid: 16'h0000, chg_at: 32, exp_bits: 32'hF0F0_5A3C};

    prio[0] = '{j1: 16'h0001, exp_data: 1'b0};
    prio[1] = '{j1: 16'h0000, exp_data: 1'b1};
    prio[2] = '{j1: 16'hFFFE, exp_data: 1'b1};
    prio[3] = '{j1: 16'h0003, exp_data: 1'b0};
    prio[4] = '{j1: 16'h1234, exp_data: 1'b1};

    hold(3);
    reset = 1'b0;
    hold(1);
    check("reset JOY_DATA", {31'd0, JOY_DATA}, 32'd1);
    check("reset bit_cnt", {26'd0, bit_cnt}, 32'd0);
    check("reset frame_done", {31'd0, frame_done}, 32'd0);
    check("reset overrun", {31'd0, overrun}, 32'd0);
    check("reset host_active", {31'd0, host_active}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      run_frame(frames[i], $sformatf("frame%0d", i));
      if (i == 0) begin
        for (int x = 0; x < 3; x++) begin
          pulse_clk();
          check($sformatf("overrun data%0d", x), {31'd0, JOY_DATA}, 32'd1);
        end
        check("overrun flag", {31'd0, overrun}, 32'd1);
        check("overrun bit_cnt", {26'd0, bit_cnt}, 32'd32);
        do_load();
        check("overrun cleared", {31'd0, overrun}, 32'd0);
        check("overrun reload bit_cnt", {26'd0, bit_cnt}, 32'd0);
      end
    end

    JOY_LOAD = 1'b0;
    hold(8);
    for (int i = 0; i < 5; i++) begin
      joystick1 = prio[i].j1;
      pulse_clk();
      check($sformatf("prio%0d bit_cnt", i), {26'd0, bit_cnt}, 32'd0);
      check($sformatf("prio%0d data", i), {31'd0, JOY_DATA}, {31'd0, prio[i].exp_data});
    end
    JOY_LOAD = 1'b1;
    hold(8);

    joystick1 = 16'h0001;
    joystick2 = 16'h8000;
    do_load();
    for (int k = 0; k < 10; k++) pulse_clk();
    check("mid bit_cnt before reset", {26'd0, bit_cnt}, 32'd10);
    reset = 1'b1;
    hold(1);
    check("midreset JOY_DATA", {31'd0, JOY_DATA}, 32'd1);
    check("midreset bit_cnt", {26'd0, bit_cnt}, 32'd0);
    check("midreset host_active", {31'd0, host_active}, 32'd0);
    reset = 1'b0;
    hold(2);
    run_frame(frames[0], "post_reset");

    reset = 1'b1;
    hold(1);
    reset = 1'b0;
    hold(1);
    check("wd idle", {31'd0, host_active}, 32'd0);
    act_cnt = 0;
    JOY_LOAD = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      if (host_active === 1'b1) act_cnt++;
      if (k == 8) JOY_LOAD = 1'b1;
    end
    check("wd active cycles", act_cnt, 32'd100);
    check("wd expired", {31'd0, host_active}, 32'd0);
    do_load();
    check("wd reload", {31'd0, host_active}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
